axi_xbar_1x2: RTL
=================

# axi_xbar_1x2

AXI4 1-master-to-2-slave crossbar that sits directly between the core's LSU memory master and the slave devices. It routes each read and write transaction by address to either the main memory slave (port 0) or the UART slave (port 1). It also returns responses, including IDs, back to the core. Read and write channels are independent: each has its own FSM, with at most one outstanding transaction per direction.

## Interface
Parameters:
- MEM_BASE, 32'h8000_0000, port 0 region base
- MEM_SIZE, 32'h0800_0000, port 0 region size in bytes
- UART_BASE, 32'ha000_03f8, port 1 region base
- UART_SIZE, 32'h0000_0008, port 1 region size in bytes

Ports (the in/out direction listed first applies to valid and payload; ready is the opposite direction):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_ar{valid,addr[31:0],id[3:0],len[7:0],size[2:0],burst[1:0]}  in, s_arready out  —  upstream read address
- s_r{valid,data[31:0],resp[1:0],id[3:0],last}  out, s_rready in  —  upstream read data
- s_aw{valid,addr,id,len,size,burst}  in, s_awready out  —  upstream write address (widths as AR)
- s_w{valid,data[31:0],strb[3:0],last}  in, s_wready out  —  upstream write data
- s_b{valid,resp[1:0],id[3:0]}  out, s_bready in  —  upstream write response
- m0_* / m1_*  mirror of the s_* set with directions reversed, to memory / UART

## Operation
- Decode: hit_uart = (addr − UART_BASE) < UART_SIZE, computed as 32-bit unsigned. hit_mem is computed the same way. UART has priority if both hit. Neither hit → unmapped.
- Read FSM states:
  - R_IDLE: s_arready=1. On AR fire, latch addr/id/len/size/burst and the target, then go to R_ADDR (mapped) or R_ERR (unmapped).
  - R_ADDR: drive the target's arvalid with the latched fields. On target arready go to R_DATA.
  - R_DATA: connect target R to s_R combinationally; the other port's rready=0. On a fire with rlast=1 go to R_IDLE.
  - R_ERR: covered under Configuration.
- Write FSM states:
  - W_IDLE: s_awready=1, s_wready=0. On AW fire, latch fields and target, then go to W_ADDR (mapped) or W_ERR (unmapped).
  - W_ADDR: drive the target's awvalid. In parallel, W is forwarded combinationally to the target (s_wready = target wready). Flags aw_done and w_done record the AW fire and the wlast fire.
  - W_ADDR exit: when both flags are set (fires in the same cycle count), go to W_RESP.
  - W_RESP: s_wready=0. Connect target B to s_B. On b fire go to W_IDLE and clear the flags.
- Slave-side IDs and payload pass through unmodified. Response resp codes are forwarded unchanged.
- Reads and writes may be in flight simultaneously to the same or to different slaves.
- Reset while busy: both FSMs return to IDLE on the next edge, in-flight transactions are abandoned, and all m*_valid outputs drop.

## Timing
- Reset values:
  - s_arready=1, s_awready=1
  - s_wready=0, s_rvalid=0, s_bvalid=0
  - all m0_/m1_ arvalid, awvalid, wvalid = 0
  - all rready/bready = 0
  - s_rdata=0, s_rresp=0, s_rid=0, s_rlast=0, s_bresp=0, s_bid=0
- Address latency: AR/AW accepted in cycle N → target valid asserted in cycle N+1. Target valid is held stable until ready.
- Data and response channels add 0 cycles (combinational pass-through).
- A new AR is accepted only after the final R beat has fired, so the minimum read-to-read turnaround is 1 cycle in R_IDLE. Writes follow the same rule after the B fire.
- A W beat presented before AW is accepted is stalled (s_wready=0 in W_IDLE).

## Configuration
- AXI_XBAR_DECERR_EN defined:
  - Unmapped reads enter R_ERR and return arlen+1 beats with rresp=2'b11, rdata=0, rid=latched id, and rlast on the final beat (beat counter is 8 bits).
  - Unmapped writes enter W_ERR: W beats are accepted (s_wready=1) and discarded until wlast, then bvalid is asserted with bresp=2'b11 and bid=latched id.
- AXI_XBAR_DECERR_EN undefined: unmapped addresses route to port 0 (memory is the default slave). R_ERR and W_ERR do not exist.

## Test plan
- Read 0x8000_0010, arid=3, len=0; memory returns 0xDEADBEEF → m0_arvalid in cycle N+1, s_rdata=0xDEADBEEF, rid=3, rlast=1, m1 stays idle.
- Write 0xa000_03f8, wdata=0x41, awid=5; W presented in the same cycle as AW fire+1 → m1 sees the write, s_bid=5, bresp=0, m0 untouched.
- Concurrent read from memory and write to UART → both complete, with no cross-talk on m0/m1 valids.
- Read 0x1000_0000, len=3, with DECERR_EN → 4 beats, resp=2'b11, rlast only on beat 4. Without DECERR_EN → the read goes to m0.
- Memory holds arready low for 5 cycles → m0_araddr and arvalid stay stable for all 5 cycles, and s_arready=0 throughout.
- rst asserted in R_DATA mid-burst → next cycle s_rvalid=0, s_arready=1, all m*_valid=0.

Source files
------------

// File: rtl/axi_xbar_1x2_if.sv
// AXI4 channel bundle (AR, R, AW, W, B) used for the crossbar's upstream port and both downstream ports.
// Handshake on every channel: a beat transfers on a rising edge where valid and ready are both high;
// the sender keeps valid and payload stable until that edge and never waits on ready before raising valid.
interface axi_xbar_1x2_if;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;

    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
        input rvalid, rdata, rresp, rid, rlast, output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input bvalid, bresp, bid, output bready
    );

    modport slave (
        input arvalid, araddr, arid, arlen, arsize, arburst, output arready,
        output rvalid, rdata, rresp, rid, rlast, input rready,
        input awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
        input wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bresp, bid, input bready
    );
endinterface

// File: rtl/axi_xbar_1x2.sv
// AXI4 1-to-2 crossbar: memory on m0, UART on m1, one outstanding transaction per direction.
// Define AXI_XBAR_DECERR_EN to answer unmapped addresses with DECERR instead of routing them to m0.
module axi_xbar_1x2 #(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE  = 32'h0800_0000,
    parameter logic [31:0] UART_BASE = 32'ha000_03f8,
    parameter logic [31:0] UART_SIZE = 32'h0000_0008
) (
    input  logic           clk,
    input  logic           rst,
    axi_xbar_1x2_if.slave  s,
    axi_xbar_1x2_if.master m0,
    axi_xbar_1x2_if.master m1,
    output logic [1:0]     r_state,
    output logic [2:0]     w_state,
    output logic           decode_miss
);
    typedef enum logic [1:0] {
        R_IDLE, R_ADDR, R_DATA
`ifdef AXI_XBAR_DECERR_EN
        , R_ERR
`endif
    } r_state_t;

    typedef enum logic [2:0] {
        W_IDLE, W_ADDR, W_RESP
`ifdef AXI_XBAR_DECERR_EN
        , W_ERR, W_ERESP
`endif
    } w_state_t;

    r_state_t    r_cur, r_nxt;
    w_state_t    w_cur, w_nxt;
    logic        r_port, w_port;
    logic [31:0] r_addr, w_addr;
    logic [3:0]  r_id, w_id;
    logic [7:0]  r_len, w_len;
    logic [2:0]  r_size, w_size;
    logic [1:0]  r_burst, w_burst;
    logic        aw_done, w_done, aw_hs, w_hs;
    logic        ar_uart, ar_mem, aw_uart, aw_mem;

    // Unsigned wrap-around makes one compare cover both region bounds.
    assign ar_uart = (s.araddr - UART_BASE) < UART_SIZE;
    assign ar_mem  = (s.araddr - MEM_BASE) < MEM_SIZE;
    assign aw_uart = (s.awaddr - UART_BASE) < UART_SIZE;
    assign aw_mem  = (s.awaddr - MEM_BASE) < MEM_SIZE;

    assign decode_miss = (s.arvalid & s.arready & ~(ar_uart | ar_mem))
                       | (s.awvalid & s.awready & ~(aw_uart | aw_mem));
    assign r_state = r_cur;
    assign w_state = w_cur;

    assign m0.araddr = r_addr;  assign m0.arid = r_id;  assign m0.arlen = r_len;
    assign m0.arsize = r_size;  assign m0.arburst = r_burst;
    assign m1.araddr = r_addr;  assign m1.arid = r_id;  assign m1.arlen = r_len;
    assign m1.arsize = r_size;  assign m1.arburst = r_burst;
    assign m0.awaddr = w_addr;  assign m0.awid = w_id;  assign m0.awlen = w_len;
    assign m0.awsize = w_size;  assign m0.awburst = w_burst;
    assign m1.awaddr = w_addr;  assign m1.awid = w_id;  assign m1.awlen = w_len;
    assign m1.awsize = w_size;  assign m1.awburst = w_burst;
    assign m0.wdata = s.wdata;  assign m0.wstrb = s.wstrb;  assign m0.wlast = s.wlast;
    assign m1.wdata = s.wdata;  assign m1.wstrb = s.wstrb;  assign m1.wlast = s.wlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur <= R_IDLE;  r_port <= 1'b0;  r_addr <= '0;  r_id <= '0;
            r_len <= '0;      r_size <= '0;    r_burst <= '0;
        end else begin
            r_cur <= r_nxt;
            if (r_cur == R_IDLE && s.arvalid) begin
                r_port <= ar_uart;  r_addr <= s.araddr;  r_id <= s.arid;
                r_len <= s.arlen;   r_size <= s.arsize;  r_burst <= s.arburst;
            end
        end
    end

`ifdef AXI_XBAR_DECERR_EN
    logic [7:0] r_beat;
    always_ff @(posedge clk) begin
        if (rst || r_cur != R_ERR) r_beat <= '0;
        else if (s.rready) r_beat <= r_beat + 8'd1;
    end
`endif

    always_comb begin
        r_nxt = r_cur;
        s.arready = 1'b0;
        s.rvalid = 1'b0;  s.rdata = '0;  s.rresp = '0;  s.rid = '0;  s.rlast = 1'b0;
        m0.arvalid = 1'b0;  m1.arvalid = 1'b0;
        m0.rready = 1'b0;   m1.rready = 1'b0;
        case (r_cur)
            R_IDLE: begin
                s.arready = 1'b1;
`ifdef AXI_XBAR_DECERR_EN
                if (s.arvalid) r_nxt = (ar_uart | ar_mem) ? R_ADDR : R_ERR;
`else
                if (s.arvalid) r_nxt = R_ADDR;
`endif
            end
            R_ADDR: begin
                if (r_port) m1.arvalid = 1'b1;
                else        m0.arvalid = 1'b1;
                if (r_port ? m1.arready : m0.arready) r_nxt = R_DATA;
            end
            R_DATA: begin
                if (r_port) begin
                    s.rvalid = m1.rvalid;  s.rdata = m1.rdata;  s.rresp = m1.rresp;
                    s.rid = m1.rid;        s.rlast = m1.rlast;  m1.rready = s.rready;
                end else begin
                    s.rvalid = m0.rvalid;  s.rdata = m0.rdata;  s.rresp = m0.rresp;
                    s.rid = m0.rid;        s.rlast = m0.rlast;  m0.rready = s.rready;
                end
                if (s.rvalid && s.rready && s.rlast) r_nxt = R_IDLE;
            end
`ifdef AXI_XBAR_DECERR_EN
            R_ERR: begin
                s.rvalid = 1'b1;  s.rresp = 2'b11;  s.rid = r_id;
                s.rlast = (r_beat == r_len);
                if (s.rready && s.rlast) r_nxt = R_IDLE;
            end
`endif
            default: r_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_cur <= W_IDLE;  w_port <= 1'b0;  w_addr <= '0;  w_id <= '0;
            w_len <= '0;      w_size <= '0;    w_burst <= '0;
            aw_done <= 1'b0;  w_done <= 1'b0;
        end else begin
            w_cur <= w_nxt;
            if (w_cur == W_IDLE && s.awvalid) begin
                w_port <= aw_uart;  w_addr <= s.awaddr;  w_id <= s.awid;
                w_len <= s.awlen;   w_size <= s.awsize;  w_burst <= s.awburst;
            end
            if (w_cur == W_ADDR) begin
                aw_done <= aw_done | aw_hs;
                w_done  <= w_done | w_hs;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_nxt = w_cur;
        aw_hs = 1'b0;  w_hs = 1'b0;
        s.awready = 1'b0;  s.wready = 1'b0;
        s.bvalid = 1'b0;   s.bresp = '0;  s.bid = '0;
        m0.awvalid = 1'b0;  m1.awvalid = 1'b0;
        m0.wvalid = 1'b0;   m1.wvalid = 1'b0;
        m0.bready = 1'b0;   m1.bready = 1'b0;
        case (w_cur)
            W_IDLE: begin
                s.awready = 1'b1;
`ifdef AXI_XBAR_DECERR_EN
                if (s.awvalid) w_nxt = (aw_uart | aw_mem) ? W_ADDR : W_ERR;
`else
                if (s.awvalid) w_nxt = W_ADDR;
`endif
            end
            W_ADDR: begin
                // AW and the W burst complete independently; the flags remember which side is done.
                if (w_port) begin
                    m1.awvalid = ~aw_done;  m1.wvalid = s.wvalid & ~w_done;
                    s.wready = m1.wready & ~w_done;  aw_hs = m1.awvalid & m1.awready;
                end else begin
                    m0.awvalid = ~aw_done;  m0.wvalid = s.wvalid & ~w_done;
                    s.wready = m0.wready & ~w_done;  aw_hs = m0.awvalid & m0.awready;
                end
                w_hs = s.wvalid & s.wready & s.wlast;
                if ((aw_done | aw_hs) && (w_done | w_hs)) w_nxt = W_RESP;
            end
            W_RESP: begin
                if (w_port) begin
                    s.bvalid = m1.bvalid;  s.bresp = m1.bresp;  s.bid = m1.bid;  m1.bready = s.bready;
                end else begin
                    s.bvalid = m0.bvalid;  s.bresp = m0.bresp;  s.bid = m0.bid;  m0.bready = s.bready;
                end
                if (s.bvalid && s.bready) w_nxt = W_IDLE;
            end
`ifdef AXI_XBAR_DECERR_EN
            W_ERR: begin
                s.wready = 1'b1;
                if (s.wvalid && s.wlast) w_nxt = W_ERESP;
            end
            W_ERESP: begin
                s.bvalid = 1'b1;  s.bresp = 2'b11;  s.bid = w_id;
                if (s.bready) w_nxt = W_IDLE;
            end
`endif
            default: w_nxt = W_IDLE;
        endcase
    end
endmodule
